// File: rtl/ls_counter_pkg.sv
// Shared constants for the LS-family counter stages (up and down variants).
package ls_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

endpackage : ls_counter_pkg

// File: rtl/ls_down_counter.sv
// Presettable, cascadable synchronous down counter with auto-reload, one-shot
// mode, borrow-out for cascading and a registered terminal-step pulse.
module ls_down_counter
    import ls_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             TC_PULSE,
    output logic             DONE
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             zero;
    logic             step;

    // Terminal detect is shared by the borrow output and the step logic.
    assign zero = (cnt_q == '0);
    assign step = ENP & ENT & ~done_q;

    always_comb begin
        cnt_d    = cnt_q;
        preset_d = preset_q;
        done_d   = done_q;
        tc_d     = 1'b0;
        if (!LOAD_n) begin
            cnt_d    = D;
            preset_d = D;
            done_d   = 1'b0;
        end else if (step) begin
            if (!zero) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                // MODE 11 falls into the default and behaves as wrap.
                case (MODE)
                    MODE_RELOAD:  cnt_d = preset_q;
                    MODE_ONESHOT: begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end
                    default:      cnt_d = '1;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q    <= '0;
            preset_q <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign Q        = cnt_q;
    assign BO       = ENT & zero;
    assign TC_PULSE = tc_q;
    assign DONE     = done_q;

endmodule : ls_down_counter
